// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming KxK valid convolution over one channel.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv_kxk_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 28,
  parameter int SHIFT  = 0,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(K*K),
  localparam int AW    = $clog2(K*K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena_in,
  input  logic                     frame_start_in,
  input  logic                     line_start_in,
  input  logic                     frame_end_in,
  input  logic signed [DATA_W-1:0] ima,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic signed [COEF_W-1:0] w_data,
  output logic                     valid,
  output logic                     frame_start_out,
  output logic                     line_start_out,
  output logic                     frame_end_out,
  output logic signed [OUT_W-1:0]  sig_layer,
  output logic                     busy
);

  localparam int NC = K * K;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(K);
  localparam int PW = DATA_W + COEF_W;
  localparam int EW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state;
  logic [CW-1:0] col;
  logic [CW-1:0] pc;
  logic [RW-1:0] row;
  logic fs_pend;
  logic acc;
  logic wrap;
  logic emit;

  logic signed [COEF_W-1:0] coef [NC];
  logic signed [DATA_W-1:0] lb   [K-1][IMG_W];
  logic signed [DATA_W-1:0] colv [K];
  logic signed [DATA_W-1:0] win  [K][K];
  logic signed [PW-1:0]     prod [NC];

  logic v1, fs1, ls1, fe1;
  logic v2, fs2, ls2, fe2;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] y;
  logic signed [EW-1:0]    y_ext;
  logic signed [EW-1:0]    max_v;
  logic signed [EW-1:0]    min_v;
  logic signed [OUT_W-1:0] sat;

  // accept decode; a frame start or line start pins the pixel to column 0
  always_comb begin
    acc  = ena_in && (frame_start_in || state != IDLE);
    pc   = (frame_start_in || line_start_in) ? '0 : col;
    wrap = (pc == CW'(IMG_W - 1));
    emit = acc && !frame_start_in && state == RUN
        && pc >= CW'(K - 1);
  end

  // frame FSM with raster counters; row saturates once the window is full
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      busy    <= 1'b0;
      fs_pend <= 1'b0;
    end else if (acc) begin
      col <= wrap ? '0 : pc + 1'b1;
      if (frame_start_in) begin
        state   <= FILL;
        row     <= '0;
        busy    <= 1'b1;
        fs_pend <= 1'b1;
      end else begin
        if (wrap && row != RW'(K - 1))
          row <= row + 1'b1;
        if (emit)
          fs_pend <= 1'b0;
        if (frame_end_in) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (state == FILL && wrap
                     && row == RW'(K - 2)) begin
          state <= RUN;
        end
      end
    end
  end

  // coefficient file, writable only between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++)
        coef[i] <= '0;
    end else if (w_we && !busy && int'(w_addr) < NC) begin
      coef[w_addr] <= w_data;
    end
  end

  // incoming column: new pixel at the bottom, older lines above it
  always_comb begin
    colv[0] = ima;
    for (int i = 1; i < K; i++)
      colv[i] = lb[i-1][pc];
  end

  // line buffers and window shift register advance on accepted pixels
  always_ff @(posedge clk) begin
    if (acc) begin
      lb[0][pc] <= ima;
      for (int i = 1; i < K - 1; i++)
        lb[i][pc] <= lb[i-1][pc];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win[r][c] <= win[r][c+1];
        win[r][K-1] <= colv[K-1-r];
      end
    end
  end

  // stage 1 control: window valid and markers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      fs1 <= 1'b0;
      ls1 <= 1'b0;
      fe1 <= 1'b0;
    end else begin
      v1  <= emit;
      fs1 <= emit && fs_pend;
      ls1 <= emit && pc == CW'(K - 1);
      fe1 <= emit && frame_end_in;
    end
  end

  // stage 2 datapath: registered products
  always_ff @(posedge clk) begin
    if (v1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod[r*K+c] <= PW'(win[r][c]) * PW'(coef[r*K+c]);
    end
  end

  // stage 2 control
  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      fs2 <= 1'b0;
      ls2 <= 1'b0;
      fe2 <= 1'b0;
    end else begin
      v2  <= v1;
      fs2 <= fs1;
      ls2 <= ls1;
      fe2 <= fe1;
    end
  end

  // adder tree, arithmetic shift, saturation and optional clamp at zero
  always_comb begin
    sum = '0;
    for (int i = 0; i < NC; i++)
      sum = sum + ACC_W'(prod[i]);
    y     = sum >>> SHIFT;
    y_ext = EW'(y);
    max_v = '0;
    max_v[OUT_W-2:0] = '1;
    min_v = '1;
    min_v[OUT_W-2:0] = '0;
    if (y_ext > max_v)
      sat = max_v[OUT_W-1:0];
    else if (y_ext < min_v)
      sat = min_v[OUT_W-1:0];
    else
      sat = y_ext[OUT_W-1:0];
`ifdef CONV_RELU_EN
    if (sat[OUT_W-1])
      sat = '0;
`endif
  end

  // stage 3: registered result and markers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid           <= 1'b0;
      frame_start_out <= 1'b0;
      line_start_out  <= 1'b0;
      frame_end_out   <= 1'b0;
      sig_layer       <= '0;
    end else begin
      valid           <= v2;
      frame_start_out <= fs2;
      line_start_out  <= ls2;
      frame_end_out   <= fe2;
      if (v2)
        sig_layer <= sat;
    end
  end

endmodule

// File: doc/conv_kxk_stream.md
# conv_kxk_stream

Parametrised streaming K×K convolution engine for one feature-map channel. Consumes a raster-scan pixel stream with frame and line markers, buffers K-1 lines internally, and emits one signed result per fully covered window ("valid" convolution, no padding). Results carry regenerated frame and line markers. The block sits between the pixel source and the downstream layer/pooling stage, and generalises the fixed 3×3 conv stage in kernel size, widths and image width. It adds a runtime-loadable kernel, a right-shift scaling stage and output saturation.

## Interface
Parameters:
- DATA_W, 8: signed input pixel width.
- COEF_W, 8: signed coefficient width.
- OUT_W, 16: signed output width.
- K, 3: kernel size, 2..7.
- IMG_W, 28: pixels per input line; must be at least K.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- ACC_W = DATA_W+COEF_W+$clog2(K*K): accumulator width (derived, not overridable).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- ena_in, in, 1: pixel qualifier. All other *_in stream signals are sampled only when ena_in=1.
- frame_start_in, in, 1: current pixel is the first pixel of a frame.
- line_start_in, in, 1: current pixel is the first pixel of a line.
- frame_end_in, in, 1: current pixel is the last pixel of a frame.
- ima, in, DATA_W: signed pixel.
- w_we, in, 1: coefficient write strobe.
- w_addr, in, $clog2(K*K): coefficient index, row-major (r*K+c).
- w_data, in, COEF_W: signed coefficient.
- valid, out, 1: sig_layer and the *_out markers are valid.
- frame_start_out, out, 1: first result of the frame.
- line_start_out, out, 1: first result of an output line.
- frame_end_out, out, 1: last result of the frame.
- sig_layer, out, OUT_W: signed convolution result.
- busy, out, 1: a frame is in progress.

## Operation
- State machine IDLE → FILL → RUN → IDLE.
  - IDLE: ignores pixels unless frame_start_in=1. A frame start clears the column and row counters and enters FILL.
  - FILL: active while row < K-1. It writes pixels into the line buffers only.
  - RUN: entered when row reaches K-1. On ena_in && frame_end_in the block accepts the pixel and returns to IDLE.
- Counters:
  - col increments per accepted pixel and wraps to 0 at IMG_W-1. The wrap increments row.
  - line_start_in forces col=0. It is used for alignment, and a mismatch is not an error.
- frame_start_in in FILL or RUN restarts the frame: counters are cleared, the state goes to FILL, and any outputs already in the pipeline still drain.
- Window:
  - K-1 line buffers of IMG_W×DATA_W plus a K×K shift register, both advanced on accepted pixels only.
  - A result is produced for an accepted pixel when state=RUN and col ≥ K-1.
  - The window's top-left corner is (row-K+1, col-K+1).
- Arithmetic:
  - sum = Σ w[r][c]·pix[r][c] at full ACC_W.
  - y = sum >>> SHIFT (arithmetic shift).
  - y is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output markers:
  - frame_start_out on the result with row=K-1, col=K-1.
  - line_start_out on every result with col=K-1.
  - frame_end_out on the result generated by the frame_end_in pixel.
- Coefficients:
  - A K*K register file, written when w_we=1 and busy=0.
  - A write while busy=1 is dropped.
  - A write to w_addr ≥ K*K is dropped.
- Reset values:
  - valid, frame_start_out, line_start_out, frame_end_out, busy and sig_layer are 0.
  - State is IDLE, counters are 0, and all coefficients are 0.
  - Line buffers are not reset. FILL guarantees they are never read before being written.
- Reset mid-frame: the pipeline is flushed, no further outputs appear for that frame, and the next frame_start_in is processed normally.

## Timing
- Latency is 3 cycles, fixed:
  - Pixel accepted at cycle t.
  - Window register updated at t+1.
  - Products registered at t+2.
  - Adder tree, shift and saturate registered at t+3, when valid is asserted.
- Throughput is one result per cycle. ena_in gaps pass through as valid gaps, with no backpressure.
- busy rises the cycle after frame_start_in is accepted. It falls the cycle after frame_end_in is accepted; results may still be draining.
- A coefficient write is visible to the next frame, one cycle after w_we.

## Configuration
- CONV_RELU_EN defined: after saturation, negative y is forced to 0. Latency is unchanged.
- CONV_RELU_EN undefined: signed saturated output is passed unchanged.

## Test plan
All tests use K=3, IMG_W=5 and a 5-line frame unless stated.
- All coefficients 1, all pixels 1 → 9 results of 9. frame_start_out on result 1, line_start_out on results 1/4/7, frame_end_out on result 9, first valid 3 cycles after pixel (2,2).
- Centre coefficient 1, others 0, pixel = row*5+col → results 6,7,8,11,12,13,16,17,18.
- Coefficients 127, pixels 127 → 32767. Pixels -128 → -32768 without CONV_RELU_EN, 0 with it. Coefficients 1, SHIFT=2, pixels 1 → 2.
- ena_in asserted every other cycle → same values and markers as the first test, each result 3 cycles after its pixel.
- rst after 12 pixels, then a fresh frame → no results from the aborted frame; the new frame matches the first test.
- w_we while busy with data 5 → ignored, results unchanged. frame_start_in at pixel 8 → frame restarts, counting from that pixel.
